ram_access_arbiter: RTL and testbench



---
 rtl/ram_access_arbiter_pkg.sv | 17 +
 rtl/ram_access_arbiter_rr_pick2.sv | 22 ++
 rtl/ram_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// rtl/ram_access_arbiter_pkg.sv - shared state encoding and requester IDs for the RAM access arbiter
//
// Purpose : package ram_arb_pkg, imported by ram_access_arbiter and rr_pick2.
// Contents: state_e  - 2-bit FSM encoding (ST_IDLE, ST_ACCESS, ST_RESP)
//           REQ0/REQ1 - requester ID constants carried in the latched command
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_access_arbiter_rr_pick2.sv
// rtl/ram_access_arbiter_rr_pick2.sv - two-way pick with a favoured-requester pointer
//
// Purpose : chooses one of two valid requesters; on contention the one named
//           by ptr_i wins, otherwise the single valid requester wins.
// Ports   : valid_i [1:0] in  - request valid per requester
//           ptr_i         in  - favoured requester on contention
//           grant_o [1:0] out - one-hot grant (all zero when nothing is valid)
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o    = 2'b00;
      grant_o[0] = valid_i[0] & (~valid_i[1] | (ptr_i == REQ0));
      grant_o[1] = valid_i[1] & (~valid_i[0] | (ptr_i == REQ1));
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - shares a 4-word RAM between two requesters
//
// Purpose : round-robin arbiter, one RAM access per grant. IDLE offers ready
//           combinationally, ACCESS drives the RAM for one cycle, RESP returns
//           read data with a one-cycle rvalid pulse to the winner.
// Config  : ARB_FIXED_PRIORITY_EN - when defined req0 always wins on
//           contention and no round-robin pointer is kept.
// Ports   : clk, rst_n (async, active low)
//           reqN_valid/we/addr/wdata in  - command from requester N
//           reqN_ready               out - command accepted this cycle
//           reqN_rvalid/rdata        out - read response for requester N
//           mem_en/addr/we/wdata     out - RAM controls, zero outside ACCESS
//           mem_rdata                in  - RAM read data, same cycle as mem_en
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                id_q, id_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          grant;

`ifdef ARB_FIXED_PRIORITY_EN
   rr_pick2 u_pick (
      .valid_i ({req1_valid, req0_valid}),
      .ptr_i   (REQ0),
      .grant_o (grant)
   );
`else
   logic                rr_ptr_q, rr_ptr_d;

   rr_pick2 u_pick (
      .valid_i ({req1_valid, req0_valid}),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= REQ0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         id_q    <= REQ0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         id_q    <= id_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      id_d        = id_q;
      rdata_d     = rdata_q;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      req0_rvalid = 1'b0;
      req1_rvalid = 1'b0;
      mem_en      = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;

      case (state_q)
         ST_ACCESS: begin
            mem_en    = 1'b1;
            mem_addr  = addr_q;
            mem_we    = we_q;
            mem_wdata = wdata_q;
            if (we_q) begin
               state_d = ST_IDLE;
            end else begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            req0_rvalid = (id_q == REQ0);
            req1_rvalid = (id_q == REQ1);
            state_d     = ST_IDLE;
         end
         default: begin
            // Ready is combinational from valid; gating with rst_n keeps it
            // low while reset is held even though the state already reads IDLE.
            if (rst_n) begin
               req0_ready = grant[0];
               req1_ready = grant[1];
            end
            if (grant[0]) begin
               we_d     = req0_we;
               addr_d   = req0_addr;
               wdata_d  = req0_wdata;
               id_d     = REQ0;
`ifndef ARB_FIXED_PRIORITY_EN
               rr_ptr_d = REQ1;
`endif
               state_d  = ST_ACCESS;
            end else if (grant[1]) begin
               we_d     = req1_we;
               addr_d   = req1_addr;
               wdata_d  = req1_wdata;
               id_d     = REQ1;
`ifndef ARB_FIXED_PRIORITY_EN
               rr_ptr_d = REQ0;
`endif
               state_d  = ST_ACCESS;
            end else begin
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   // Both requesters see the same held read register; rvalid says whose it is.
   assign req0_rdata = rdata_q;
   assign req1_rdata = rdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;

   localparam int AW = 2;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req0_we = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req0_ready, req0_rvalid;
   logic [DW-1:0] req0_rdata;
   logic          req1_valid = 1'b0, req1_we = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req1_ready, req1_rvalid;
   logic [DW-1:0] req1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
      .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
      .req1_rdata(req1_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // 4-word RAM: combinational read, write at the clock edge ending the access
   logic [DW-1:0] ram [4];
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int en_cnt  = 0;

   typedef struct { int id; int data; int cyc; } exp_t;
   exp_t sb[$];

   typedef struct { int id; bit we; int addr; int wdata; int exp; } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, got, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   // Drive one command, wait up to max_wait extra cycles for ready, push the
   // expected read response on acceptance, drop valid after the accept edge.
   task automatic issue(input int id, input bit we, input int addr, input int wdata,
                        input int exp, input int max_wait, input string nm);
      int  waited = 0;
      bit  acc = 1'b0;
      if (id == 0) begin
         req0_we = we; req0_addr = AW'(addr); req0_wdata = DW'(wdata); req0_valid = 1'b1;
      end else begin
         req1_we = we; req1_addr = AW'(addr); req1_wdata = DW'(wdata); req1_valid = 1'b1;
      end
      while (!acc && waited <= max_wait) begin
         @(negedge clk);
         if ((id == 0) ? req0_ready : req1_ready) acc = 1'b1;
         else waited++;
      end
      chk(nm, 32'(acc), 32'd1);
      if (acc && !we) sb.push_back('{id, exp, cyc});
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Monitor: bus-idle rules, exclusive ready, read responses vs scoreboard
   initial begin
      bit prev_en = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            prev_en = 1'b0;
         end else begin
            if (req0_ready && req1_ready) bad("ready_exclusive");
            if (!mem_en) chk("mem_idle_zero", {26'd0, mem_addr, mem_we, mem_wdata}, 32'd0);
            if (mem_en && prev_en) bad("mem_en_width");
            if (mem_en) en_cnt++;
            prev_en = mem_en;
            if (req0_rvalid || req1_rvalid) begin
               if (req0_rvalid && req1_rvalid) bad("rvalid_exclusive");
               else if (sb.size() == 0) bad("unexpected_rvalid");
               else begin
                  e = sb.pop_front();
                  chk("rvalid_id", 32'(req1_rvalid), 32'(e.id));
                  chk("rdata", 32'(req1_rvalid ? req1_rdata : req0_rdata), 32'(e.data));
                  chk("rvalid_latency", 32'(cyc), 32'(e.cyc + 2));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g[$];
      int budget;
      int exp_g;

      for (int i = 0; i < 4; i++) begin
         tbl[i]   = '{i % 2, 1'b1, i, i + 1, 0};
         tbl[i+4] = '{(i + 1) % 2, 1'b0, i, 0, i + 1};
      end

      // Reset with both requesters valid
      req0_we = 1'b1; req0_addr = 2'd0; req0_wdata = 4'h5; req0_valid = 1'b1;
      req1_we = 1'b1; req1_addr = 2'd1; req1_wdata = 4'h6; req1_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("reset_ready0", 32'(req0_ready), 32'd0);
         chk("reset_ready1", 32'(req1_ready), 32'd0);
         chk("reset_mem_en", 32'(mem_en), 32'd0);
         chk("reset_rvalid", 32'(req0_rvalid | req1_rvalid), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Contention: both hold valid, record the grant order
      budget = 0;
      while (g.size() < 6 && budget < 60) begin
         @(negedge clk);
         budget++;
         if (req0_ready) g.push_back(0);
         else if (req1_ready) g.push_back(1);
      end
      for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
         exp_g = 0;
`else
         exp_g = i % 2;
`endif
         chk("contention_grant", (g.size() > i) ? 32'(g[i]) : 32'hFFFF_FFFF, 32'(exp_g));
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // req0 write then read back
      issue(0, 1'b1, 2, 'hA, 0, 10, "t2_write_accept");
      issue(0, 1'b0, 2, 0, 'hA, 10, "t2_read_accept");
      repeat (4) @(posedge clk);
      #1;
      chk("t2_sb_drained", 32'(sb.size()), 32'd0);

      // Leave pointer at req0 (last grant req1), then lone req1 must win at once
      issue(1, 1'b1, 3, 'h7, 0, 10, "t4_setup_accept");
      @(posedge clk); #1;
      issue(1, 1'b1, 3, 'h9, 0, 0, "t4_no_bubble");
      @(posedge clk); #1;

      // Table: all four addresses written then read back, one mem_en per grant
      en_cnt = 0;
      for (int i = 0; i < 8; i++)
         issue(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 10, "tbl_accept");
      repeat (4) @(posedge clk);
      #1;
      chk("tbl_mem_en_count", 32'(en_cnt), 32'd8);
      chk("tbl_sb_drained", 32'(sb.size()), 32'd0);

      // Mid-access reset on a req0 read
      issue(0, 1'b0, 3, 0, 4, 10, "t6_read_accept");
      chk("t6_access_mem_en", 32'(mem_en), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_mem_en_async_drop", 32'(mem_en), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      req0_we = 1'b1; req0_addr = 2'd0; req0_wdata = 4'h3; req0_valid = 1'b1;
      req1_we = 1'b1; req1_addr = 2'd1; req1_wdata = 4'hC; req1_valid = 1'b1;
      rst_n = 1'b1;
      budget = 0;
      exp_g = -1;
      while (exp_g < 0 && budget < 10) begin
         @(negedge clk);
         budget++;
         if (req0_ready) exp_g = 0;
         else if (req1_ready) exp_g = 1;
      end
      chk("t6_first_grant_after_reset", 32'(exp_g), 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
